// File: rtl/imem_cache_pkg.sv
// rtl/imem_cache_pkg.sv - shared FSM encoding, address-split width helpers and NOP word
package imem_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Byte-offset bits [1:0] are never part of the tag.
  function automatic int tag_w(input int lines, input int words_per_line);
    return 30 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - flop-based valid/tag/data arrays with combinational read
// and a single synchronous write port; only the valid bits are cleared by reset.
module icache_line_store
  import imem_cache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int OW             = off_w(WORDS_PER_LINE),
  parameter int IW             = idx_w(LINES),
  parameter int TW             = tag_w(LINES, WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic [IW-1:0] wr_line,
  input  logic [OW-1:0] wr_word,
  input  logic          wr_data_en,
  input  logic [31:0]   wr_data,
  input  logic          tag_we,
  input  logic [TW-1:0] wr_tag,
  input  logic          valid_set,
  input  logic          valid_clr
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q[wr_line] <= 1'b0;
    end else if (valid_set) begin
      valid_q[wr_line] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_data_en) begin
      data_q[wr_line][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tag_q[wr_line] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/imem_cache.sv
// rtl/imem_cache.sv - direct-mapped read-only instruction cache, zero-wait hits, line fill on miss.
// Optional IMEM_CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module imem_cache
  import imem_cache_pkg::*;
#(
  parameter int LINES                = 16,
  parameter int WORDS_PER_LINE       = 4,
  parameter int RESET_VECTOR_PRELOAD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_raddr,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef IMEM_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OW = off_w(WORDS_PER_LINE);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, WORDS_PER_LINE);

  logic [OW-1:0] cpu_off;
  logic [IW-1:0] cpu_idx;
  logic [TW-1:0] cpu_tag;

  assign cpu_off = cpu_raddr[2 +: OW];
  assign cpu_idx = cpu_raddr[2+OW +: IW];
  assign cpu_tag = cpu_raddr[31 -: TW];

  // Byte-lane bits and the reserved preload parameter carry no function.
  logic unused_bits;
  assign unused_bits = ^{cpu_raddr[1:0], 32'(RESET_VECTOR_PRELOAD)};

  state_t        state, state_nx;
  logic [TW-1:0] miss_tag;
  logic [IW-1:0] miss_index;
  logic [OW-1:0] wc;

  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;

  logic          hit;
  logic          miss_start;
  logic [IW-1:0] wr_line;
  logic          wr_data_en;
  logic          tag_we;
  logic          valid_set;
  logic          valid_clr;

  icache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .OW             (OW),
    .IW             (IW),
    .TW             (TW)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (cpu_idx),
    .rd_offset  (cpu_off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_line    (wr_line),
    .wr_word    (wc),
    .wr_data_en (wr_data_en),
    .wr_data    (mem_rdata),
    .tag_we     (tag_we),
    .wr_tag     (miss_tag),
    .valid_set  (valid_set),
    .valid_clr  (valid_clr)
  );

  always_comb begin
    state_nx   = state;
    hit        = 1'b0;
    stall      = 1'b1;
    cpu_rdata  = NOP;
    mem_req    = 1'b0;
    mem_addr   = 32'h0;
    miss_start = 1'b0;
    wr_line    = miss_index;
    wr_data_en = 1'b0;
    tag_we     = 1'b0;
    valid_set  = 1'b0;
    valid_clr  = 1'b0;

    case (state)
      ST_IDLE: begin
        hit = rd_valid && (rd_tag == cpu_tag);
        if (hit) begin
          stall     = 1'b0;
          cpu_rdata = rd_data;
        end else begin
          // Invalidate up front so a partially filled line can never hit.
          miss_start = 1'b1;
          wr_line    = cpu_idx;
          valid_clr  = 1'b1;
          state_nx   = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag, miss_index, wc, 2'b00};
        if (mem_ack) begin
          wr_data_en = 1'b1;
          if (wc == OW'(WORDS_PER_LINE - 1)) begin
            tag_we    = 1'b1;
            valid_set = 1'b1;
            state_nx  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      wc    <= '0;
    end else begin
      state <= state_nx;
      if (miss_start) begin
        wc <= '0;
      end else if (wr_data_en) begin
        wc <= wc + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && miss_start) begin
      miss_tag   <= cpu_tag;
      miss_index <= cpu_idx;
    end
  end

`ifdef IMEM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_cache.sv
// tb/tb_imem_cache.sv - scoreboard bench: stimulus queues expected fetch addresses and
// instruction words, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_imem_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_raddr = 32'h0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef IMEM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;
  int ack_gap  = 2;
  int gap_cnt  = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  imem_cache #(
    .LINES                (16),
    .WORDS_PER_LINE       (4),
    .RESET_VECTOR_PRELOAD (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_raddr  (cpu_raddr),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef IMEM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line at 0x0 holds 0x11,0x22,0x33,0x44; other lines get the line base folded in.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:4], 12'h000} ^ (32'h11 * ({30'd0, a[3:2]} + 32'd1));
  endfunction

  // Backing memory: acks every (ack_gap+1)-th cycle of an active request.
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req && !reset) begin
      if (gap_cnt == ack_gap) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        gap_cnt   = 0;
      end else begin
        gap_cnt++;
      end
    end else begin
      gap_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      ack_seen++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_addr: got %h expected no request", mem_addr);
      end else begin
        check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
    end
    if (!reset && !stall && exp_data_q.size() != 0) begin
      check("cpu_rdata", cpu_rdata, exp_data_q.pop_front());
    end
  end

  task automatic push_line(input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back({addr[31:4], 4'h0} + 32'(4 * i));
    end
  endtask

  task automatic measure_stall(output int n);
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic access(input string name, input logic [31:0] addr,
                        input logic [31:0] exp, input bit miss);
    int n;
    @(posedge clk);
    #1;
    if (miss) push_line(addr);
    exp_data_q.push_back(exp);
    cpu_raddr = addr;
    measure_stall(n);
    check({name, "_stall_cycles"}, 32'(n), miss ? 32'd14 : 32'd0);
  endtask

  initial begin
    int n;
    int base;

    reset = 1'b1;
    cpu_raddr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd1);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
`ifdef IMEM_CACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif

    // First miss straight out of reset.
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_line(32'h0);
    exp_data_q.push_back(32'h11);
    measure_stall(n);
    check("first_miss_stall_cycles", 32'(n), 32'd14);
`ifdef IMEM_CACHE_STATS_EN
    repeat (5) @(negedge clk);
    check("stats_hit_count", hit_count, 32'd5);
    check("stats_miss_count", miss_count, 32'd1);
`endif

    access("hit_0x8", 32'h8, 32'h33, 1'b0);
    access("hit_0xc", 32'hC, 32'h44, 1'b0);

    // Same index, different tag.
    access("evict_0x100", 32'h100, 32'h0001_0011, 1'b1);
    access("hit_0x104", 32'h104, 32'h0001_0022, 1'b0);
    access("remiss_0x0", 32'h0, 32'h11, 1'b1);

    // Branch redirect while the 0x40 line is filling.
    @(posedge clk);
    #1;
    push_line(32'h40);
    push_line(32'h80);
    exp_data_q.push_back(32'h8011);
    cpu_raddr = 32'h40;
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      if (n == 4) cpu_raddr = 32'h80;
      @(negedge clk);
    end
    check("redirect_stall_cycles", 32'(n), 32'd28);
    access("hit_0x4c", 32'h4C, 32'h4044, 1'b0);

    // Reset after two of four words of the 0xC0 line.
    @(posedge clk);
    #1;
    exp_addr_q.push_back(32'hC0);
    exp_addr_q.push_back(32'hC4);
    base = ack_seen;
    cpu_raddr = 32'hC0;
    n = 0;
    while (ack_seen < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midfill_acks", 32'(ack_seen - base), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midfill_reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("midfill_reset_mem_addr", mem_addr, 32'h0);
    check("midfill_reset_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_line(32'hC0);
    exp_data_q.push_back(32'hC011);
    measure_stall(n);
    check("after_reset_remiss_stall_cycles", 32'(n), 32'd14);

    @(posedge clk);
    @(negedge clk);
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
